// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: req/ack fetch engine prefetching {PC+step, instr} pairs into a flushable queue
module instruction_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int PC_STEP = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchAddress,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   valid,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic [INSTR_WIDTH-1:0] instruction
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ADDR_WIDTH-1:0]  ent_pc_q [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] ent_ins_q [QUEUE_DEPTH];
  logic                   push, pop, space;
  logic [ADDR_WIDTH-1:0]  nxt_addr;
  assign valid       = count_q != '0;
  assign PC          = valid ? ent_pc_q[rd_ptr_q] : '0;
  assign instruction = valid ? ent_ins_q[rd_ptr_q] : '0;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  always_comb begin
    pop      = valid && !freeze && !branchTaken;
    push     = (state_q == S_WAIT) && mem_ack && !branchTaken;
    count_d  = branchTaken ? '0 : count_q + CW'(push) - CW'(pop);
    rd_ptr_d = branchTaken ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d = branchTaken ? '0 : wr_ptr_q + PW'(push);
    space    = count_d < CW'(QUEUE_DEPTH);
    nxt_addr = mem_addr_q + STEP;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (branchTaken) begin
          fetch_pc_d = branchAddress;
        end else if (space) begin
          state_d    = S_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          fetch_pc_d = branchTaken ? branchAddress : nxt_addr;
          if (!branchTaken && space) begin
            mem_addr_d = nxt_addr;
          end else begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end else if (branchTaken) begin
          state_d    = S_DRAIN;
          fetch_pc_d = branchAddress;
        end
      end
      S_DRAIN: begin
        // the stale request must complete before a new one may go out
        if (branchTaken) fetch_pc_d = branchAddress;
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[wr_ptr_q]  <= nxt_addr;
      ent_ins_q[wr_ptr_q] <= mem_rdata;
    end
  end
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised successor to the single-cycle instruction fetch stage. A fetch engine talks to instruction memory over a req/ack handshake and tolerates multi-cycle memory latency. It prefetches sequential instructions into a QUEUE_DEPTH-entry buffer of {PC+step, instruction} pairs. The buffer feeds the decode stage; branchTaken flushes the buffer and redirects fetch. Downstream freeze stalls only the output side, so prefetch continues while decode is frozen.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address.
INSTR_WIDTH, 32, width of an instruction word.
QUEUE_DEPTH, 4, prefetch buffer entries; power of two, at least 2.
PC_STEP, 4, address increment per sequential fetch.
RESET_PC, 0, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
freeze  in  1  decode stall; holds the queue head.
branchTaken  in  1  flush and redirect request.
branchAddress  in  ADDR_WIDTH  redirect target.
mem_req  out  1  memory request, registered.
mem_addr  out  ADDR_WIDTH  request address, registered, stable while mem_req=1.
mem_ack  in  1  memory done; mem_rdata is valid in the same cycle.
mem_rdata  in  INSTR_WIDTH  fetched instruction.
valid  out  1  queue head holds a valid entry.
PC  out  ADDR_WIDTH  head entry fetch address + PC_STEP; 0 when the queue is empty.
instruction  out  INSTR_WIDTH  head instruction; 0 when the queue is empty.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, fetch_pc=RESET_PC, queue empty, count=0, mem_req=0, mem_addr=0, valid=0, PC=0, instruction=0. Reset mid-transaction abandons the outstanding request; memory must tolerate a dropped req.
- Queue: circular buffer with read pointer, write pointer and count, where count width = clog2(QUEUE_DEPTH+1). valid = (count != 0). Outputs are combinational from the head entry.
- Pop: valid && !freeze && !branchTaken.
- Push: an accepted ack in WAIT with no branchTaken; stores {mem_addr+PC_STEP, mem_rdata}.
- Push and pop in the same cycle: count is unchanged.
- Pointer wrap: modulo QUEUE_DEPTH.
- Space rule: at most one request is outstanding. A request is issued only if count_next < QUEUE_DEPTH, so a push never overflows.
- FSM states are IDLE, WAIT and DRAIN.
- IDLE:
  - If !branchTaken and space is available: go to WAIT next cycle with mem_req=1 and mem_addr=fetch_pc.
  - If branchTaken: fetch_pc=branchAddress and stay in IDLE for that cycle.
- WAIT:
  - Hold mem_req and mem_addr until mem_ack.
  - On ack without branch: push and set fetch_pc=mem_addr+PC_STEP.
  - If space remains after push/pop, stay in WAIT with mem_addr=fetch_pc+PC_STEP, mem_req=1 (back-to-back).
  - Otherwise go to IDLE with mem_req=0.
- Branch handling:
  - branchTaken in any state: queue is cleared (count=0, pointers reset) on that edge; valid=0 the next cycle; the head is not popped.
  - branchTaken in WAIT with mem_ack the same cycle: data is discarded, fetch_pc=branchAddress, go to IDLE.
  - branchTaken in WAIT without mem_ack: go to DRAIN with fetch_pc=branchAddress.
  - The old request stays asserted with its address unchanged until ack.
- DRAIN:
  - Keep mem_req=1 until mem_ack, then discard the data, drop mem_req and go to IDLE.
  - A further branchTaken in DRAIN overwrites fetch_pc and keeps the state in DRAIN.
- Freeze:
  - Blocks pop only; fetching continues until the queue is full.
  - freeze and branchTaken together: the flush wins.
- Throughput: with mem_ack tied to 1 and freeze=0, one instruction per cycle after a 2-cycle start-up. The first valid appears 2 edges after rst deasserts.
- Arithmetic: PC and fetch_pc additions wrap modulo 2^ADDR_WIDTH.

Test Plan:
- Reset then mem_ack=1 and mem_rdata=addr-tagged: mem_addr sequence 0,4,8,…; valid rises at the 2nd edge with PC=4 and instruction=word@0; after that, one entry per cycle with PC=8, 12, ….
- freeze=1 held, mem_ack=1: queue fills to 4 (PC 4..16 queued); mem_req drops; head is held. Release freeze: head advances each cycle, and fetch resumes at 0x10.
- mem_ack delayed 3 cycles per request: mem_addr is stable and mem_req=1 for 3 cycles; each instruction appears after its ack; no duplicate or lost PC.
- branchTaken with branchAddress=0x100 while WAIT on 0x8 without ack: valid=0 next cycle; DRAIN until ack; the word@0x8 is discarded; next request is 0x100; first head PC=0x104.
- branchTaken coincident with mem_ack: returned data is not queued; next mem_addr equals branchAddress.
- rst asserted while WAIT and the queue is partly full: next cycle mem_req=0, valid=0, and fetch restarts at RESET_PC.
